// File: rtl/dds_nco.sv
// dds_nco -- numerically controlled oscillator with quadrature outputs.
//
// A phase accumulator advances by a runtime-loadable tuning word. Its top
// LUT_AW bits, plus a 2-bit quarter-cycle phase offset, address a
// quarter-wave sine table. The result is two offset-binary samples
// (cosine, sine) that can drive a DAC directly.
//
// The phase offset can be applied as soon as it is loaded. It can also be
// held pending until the next carrier-cycle boundary (accumulator carry or
// sync), so that DPSK/QPSK symbol changes land on whole cycles.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   en         advance the accumulator this cycle
//   sync       zero the accumulator (takes priority over en)
//   fcw_in     frequency tuning word
//   fcw_load   capture fcw_in (the same edge still steps with the old word)
//   pm_in      phase offset in units of 90 degrees
//   pm_load    request a phase offset change
//   cos_out    offset-binary cosine sample
//   sin_out    offset-binary sine sample
//   out_valid  sample pair comes from an enabled step (en delayed 2 cycles)
//   wrap       one-cycle pulse following an accumulator carry
module dds_nco #(
    parameter int              ACC_W      = 24,
    parameter int              LUT_AW     = 8,
    parameter int              OUT_W      = 8,
    parameter logic [ACC_W-1:0] FCW_RST   = ACC_W'(65536),
    parameter int              PM_AT_WRAP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [ACC_W-1:0] fcw_in,
    input  logic             fcw_load,
    input  logic [1:0]       pm_in,
    input  logic             pm_load,
    output logic [OUT_W-1:0] cos_out,
    output logic [OUT_W-1:0] sin_out,
    output logic             out_valid,
    output logic             wrap
);

    localparam int N     = 2 ** LUT_AW;
    localparam int QN    = N / 4;
    localparam int AMP   = 2 ** (OUT_W - 1) - 1;
    localparam int MAG_W = OUT_W - 1;

    localparam logic [OUT_W-1:0]  MID      = OUT_W'(2 ** (OUT_W - 1));
    localparam logic [OUT_W-1:0]  POS_FULL = MID + OUT_W'(AMP);
    localparam logic [LUT_AW-2:0] QN_IDX   = (LUT_AW - 1)'(QN);
    localparam logic [LUT_AW-1:0] QTR      = LUT_AW'(QN);

    localparam real PI = 3.14159265358979323846;

    // Round half away from zero.
    function automatic int round_haz(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(-x + 0.5);
    endfunction

    // Sine over [0, pi/2]; the series converges far below one LSB there.
    function automatic real sin_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return sin_series_ret(sum);
    endfunction

    function automatic real sin_series_ret(input real v);
        return v;
    endfunction

    // Quarter-wave table, entries 0..QN inclusive, so that the quadrant
    // edges (0, 90, 180, 270 degrees) are exact in every quadrant.
    function automatic logic [QN:0][MAG_W-1:0] build_qtab();
        logic [QN:0][MAG_W-1:0] t;
        for (int i = 0; i <= QN; i++)
            t[i] = MAG_W'(round_haz(real'(AMP) *
                          sin_series(PI / 2.0 * real'(i) / real'(QN))));
        return t;
    endfunction

    localparam logic [QN:0][MAG_W-1:0] QTAB = build_qtab();

    // Signed sine of a LUT phase by quadrant folding. Rounding is
    // odd-symmetric, so negating the table value stays bit-exact.
    function automatic logic signed [OUT_W-1:0] quarter_lookup(
        input logic [LUT_AW-1:0] ph
    );
        logic [LUT_AW-3:0]       r;
        logic [LUT_AW-2:0]       idx;
        logic signed [OUT_W-1:0] mag;
        r   = ph[LUT_AW-3:0];
        idx = ph[LUT_AW-2] ? (QN_IDX - {1'b0, r}) : {1'b0, r};
        mag = signed'({1'b0, QTAB[idx]});
        return ph[LUT_AW-1] ? -mag : mag;
    endfunction

    function automatic logic [OUT_W-1:0] to_offset(
        input logic signed [OUT_W-1:0] v
    );
        return MID + unsigned'(v);
    endfunction

    logic [ACC_W-1:0]  acc_p0;
    logic [ACC_W-1:0]  fcw;
    logic [1:0]        pm_off;
    logic [1:0]        pm_pend;
    logic              pend;
    logic [ACC_W:0]    acc_sum;
    logic              carry;
    logic [LUT_AW-1:0] phase_p1;
    logic              vld_p1;

    assign acc_sum = {1'b0, acc_p0} + {1'b0, fcw};
    assign carry   = en & ~sync & acc_sum[ACC_W];

    // ---- stage p0: accumulator, tuning word, phase offset ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0  <= '0;
            fcw     <= FCW_RST;
            pm_off  <= 2'd0;
            pm_pend <= 2'd0;
            pend    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            if (sync)
                acc_p0 <= '0;
            else if (en)
                acc_p0 <= acc_sum[ACC_W-1:0];

            if (fcw_load)
                fcw <= fcw_in;

            wrap <= carry;

            if (PM_AT_WRAP != 0) begin
                // A load on the boundary edge itself takes effect at once;
                // otherwise a pending load is committed at the boundary.
                if (carry || sync) begin
                    if (pm_load)
                        pm_off <= pm_in;
                    else if (pend)
                        pm_off <= pm_pend;
                    pend <= 1'b0;
                end else if (pm_load) begin
                    pm_pend <= pm_in;
                    pend    <= 1'b1;
                end
            end else if (pm_load) begin
                pm_off <= pm_in;
            end
        end
    end

    // ---- stage p1: LUT phase with quarter-cycle offset ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            phase_p1 <= acc_p0[ACC_W-1 -: LUT_AW] + {pm_off, {(LUT_AW - 2){1'b0}}};
            vld_p1   <= en;
        end
    end

    // ---- stage p2: table lookup, offset-binary outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_out   <= POS_FULL;
            sin_out   <= MID;
            out_valid <= 1'b0;
        end else begin
            cos_out   <= to_offset(quarter_lookup(phase_p1 + QTR));
            sin_out   <= to_offset(quarter_lookup(phase_p1));
            out_valid <= vld_p1;
        end
    end

endmodule

// File: tb/tb_dds_nco.sv
// tb_dds_nco -- scoreboard bench for dds_nco at its default parameters.
// A behavioural model steps alongside the DUT; each edge it pushes the
// expected sample pair, which is popped and compared one edge later when
// it reaches the outputs.
module tb_dds_nco;

    localparam int  ACC_W  = 24;
    localparam int  LUT_AW = 8;
    localparam int  OUT_W  = 8;
    localparam int  N      = 256;
    localparam int  AMPV   = 127;
    localparam int  MIDV   = 128;
    localparam real PI     = 3.14159265358979323846;

    logic             clk;
    logic             rst;
    logic             en;
    logic             sync;
    logic [ACC_W-1:0] fcw_in;
    logic             fcw_load;
    logic [1:0]       pm_in;
    logic             pm_load;
    logic [OUT_W-1:0] cos_out;
    logic [OUT_W-1:0] sin_out;
    logic             out_valid;
    logic             wrap;

    dds_nco #(
        .ACC_W      (ACC_W),
        .LUT_AW     (LUT_AW),
        .OUT_W      (OUT_W),
        .FCW_RST    (24'd65536),
        .PM_AT_WRAP (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .fcw_in    (fcw_in),
        .fcw_load  (fcw_load),
        .pm_in     (pm_in),
        .pm_load   (pm_load),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cosv;
        int sinv;
        int vld;
        int p;
    } exp_t;

    exp_t sb[$];

    logic [ACC_W-1:0] m_acc;
    logic [ACC_W-1:0] m_fcw;
    int               m_pm;
    int               m_ppend;
    bit               m_pend;
    bit               m_wrap;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    endtask

    function automatic int rhaz(input real x);
        if (x >= 0.0)
            return $rtoi(x + 0.5);
        else
            return -$rtoi(-x + 0.5);
    endfunction

    function automatic exp_t make_exp(input int p, input int v);
        exp_t e;
        real  ang;
        ang    = 2.0 * PI * real'(p) / real'(N);
        e.p    = p;
        e.vld  = v;
        e.cosv = MIDV + rhaz(real'(AMPV) * $cos(ang));
        e.sinv = MIDV + rhaz(real'(AMPV) * $sin(ang));
        return e;
    endfunction

    task automatic model_reset();
        m_acc   = '0;
        m_fcw   = 24'd65536;
        m_pm    = 0;
        m_ppend = 0;
        m_pend  = 1'b0;
        m_wrap  = 1'b0;
        sb.delete();
        sb.push_back(make_exp(0, 0));
    endtask

    task automatic check_outputs(input exp_t e);
        chk("cos", 32'(cos_out), 32'(e.cosv));
        chk("sin", 32'(sin_out), 32'(e.sinv));
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        case (e.p)
            0:   begin chk("cos_p0", 32'(cos_out), 255);   chk("sin_p0", 32'(sin_out), 128);   end
            64:  begin chk("cos_p64", 32'(cos_out), 128);  chk("sin_p64", 32'(sin_out), 255);  end
            128: begin chk("cos_p128", 32'(cos_out), 1);   chk("sin_p128", 32'(sin_out), 128); end
            192: begin chk("cos_p192", 32'(cos_out), 128); chk("sin_p192", 32'(sin_out), 1);   end
            default: ;
        endcase
    endtask

    function automatic bit model_carry_next();
        logic [ACC_W:0] s;
        s = {1'b0, m_acc} + {1'b0, m_fcw};
        return en && !sync && s[ACC_W];
    endfunction

    // One clock: model update at the edge, compare 1 time unit later.
    task automatic step();
        exp_t           e;
        logic [ACC_W:0] s;
        bit             cy;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            s  = {1'b0, m_acc} + {1'b0, m_fcw};
            cy = en && !sync && s[ACC_W];
            e  = make_exp((int'(m_acc[ACC_W-1 -: LUT_AW]) + m_pm * (N / 4)) % N, int'(en));
            sb.push_back(e);
            m_wrap = cy;
            if (cy || sync) begin
                if (pm_load)
                    m_pm = int'(pm_in);
                else if (m_pend)
                    m_pm = m_ppend;
                m_pend = 1'b0;
            end else if (pm_load) begin
                m_ppend = int'(pm_in);
                m_pend  = 1'b1;
            end
            if (sync)
                m_acc = '0;
            else if (en)
                m_acc = s[ACC_W-1:0];
            if (fcw_load)
                m_fcw = fcw_in;
        end
        #1;
        if (rst)
            check_outputs(sb[0]);
        else if (sb.size() >= 2)
            check_outputs(sb.pop_front());
        else
            chk("sb_depth", 32'(sb.size()), 2);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic seek_phase(input int p, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (int'(m_acc[ACC_W-1 -: LUT_AW]) == p)
                found = 1'b1;
            else
                step();
        end
        if (!found)
            chk(tag, 0, 1);
    endtask

    task automatic seek_carry(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (model_carry_next())
                found = 1'b1;
            else
                step();
        end
        if (!found)
            chk(tag, 0, 1);
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(sb[0]);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        sync     = 1'b0;
        fcw_in   = '0;
        fcw_load = 1'b0;
        pm_in    = 2'd0;
        pm_load  = 1'b0;
        model_reset();

        run(3);
        rst = 1'b0;
        run(8);

        en = 1'b1;
        run(300);

        // Deferred offset: load 180 degrees mid-cycle, see it at the wrap.
        seek_phase(100, "seek_p100");
        pm_in = 2'd2; pm_load = 1'b1;
        step();
        pm_load = 1'b0;
        run(300);

        // Offset load coinciding with the carry edge takes effect at once.
        pm_in = 2'd1;
        seek_carry("seek_carry_pm");
        pm_load = 1'b1;
        step();
        pm_load = 1'b0;
        run(20);

        // Sync mid-cycle.
        seek_phase(50, "seek_p50");
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(10);

        // Sync on a carry-qualifying edge with an offset pending.
        pm_in = 2'd3; pm_load = 1'b1;
        step();
        pm_load = 1'b0;
        seek_carry("seek_carry_sync");
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(10);

        en = 1'b0;
        run(5);
        en = 1'b1;
        run(5);

        // Double the tuning word.
        fcw_in = 24'd131072; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        run(300);

        // Asynchronous reset with an offset pending.
        pm_in = 2'd2; pm_load = 1'b1;
        step();
        pm_load = 1'b0;
        run(3);
        async_reset_pulse();
        run(300);

        // Zero tuning word: outputs hold while still valid.
        fcw_in = '0; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        run(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
